eight_bit_select_adder: RTL and testbench

Pipelined 8-bit carry-select adder: registers two 8-bit operands and a carry-in, and adds them as two 4-bit nibbles. The upper nibble is precomputed for both carry-in values and selected by the lower nibble's carry-out. It produces a registered 8-bit sum and carry-out. It is a standalone datapath block: one new operation accepted every clock, fixed latency, no handshake.

---
 rtl/eight_bit_select_adder_if.sv | 25 ++
 rtl/eight_bit_select_adder.sv | 89 ++++++++
 tb/tb_eight_bit_select_adder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/eight_bit_select_adder_if.sv
// Operand/result bundle for the pipelined 8-bit carry-select adder.
// The master drives the operands and the slave returns the registered sum and carry-out.
interface eight_bit_select_adder_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] output_sum;
    logic       output_Cout;

    modport master (
        output A,
        output B,
        output Cin,
        input  output_sum,
        input  output_Cout
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output output_sum,
        output output_Cout
    );
endinterface

// File: rtl/eight_bit_select_adder.sv
// Three-stage 8-bit carry-select adder with stages: capture, nibble compute, and high-nibble select.
// The high nibble is precomputed for both carries, and the low nibble's carry picks the result.
module eight_bit_select_adder (
    input logic                      clk,
    input logic                      reset,
    eight_bit_select_adder_if.slave  bus
);

    // Returns {carry_out, sum[3:0]} from four chained 1-bit full adders.
    function automatic logic [4:0] ripple4(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
        logic [4:0] r;
        logic       c_i;
        c_i = c;
        r   = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = a[i] ^ b[i] ^ c_i;
            c_i  = (a[i] & b[i]) | (c_i & (a[i] ^ b[i]));
        end
        r[4] = c_i;
        return r;
    endfunction

    // Stage 1
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       cin_q;

    // Stage 2
    logic [3:0] sum_lo_q;
    logic       c4_q;
    logic [3:0] sum_hi0_q;
    logic       carry_hi0_q;
    logic [3:0] sum_hi1_q;
    logic       carry_hi1_q;

    // Stage 3
    logic [7:0] sum_q;
    logic       cout_q;

    logic [4:0] lo_res;
    logic [4:0] hi0_res;
    logic [4:0] hi1_res;
    logic [3:0] sel_sum_hi;
    logic       sel_carry;

    always_comb begin
        lo_res  = ripple4(a_q[3:0], b_q[3:0], cin_q);
        hi0_res = ripple4(a_q[7:4], b_q[7:4], 1'b0);
        hi1_res = ripple4(a_q[7:4], b_q[7:4], 1'b1);
    end

    always_comb begin
        sel_sum_hi = c4_q ? sum_hi1_q : sum_hi0_q;
        sel_carry  = c4_q ? carry_hi1_q : carry_hi0_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            sum_lo_q    <= '0;
            c4_q        <= 1'b0;
            sum_hi0_q   <= '0;
            carry_hi0_q <= 1'b0;
            sum_hi1_q   <= '0;
            carry_hi1_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            a_q         <= bus.A;
            b_q         <= bus.B;
            cin_q       <= bus.Cin;
            sum_lo_q    <= lo_res[3:0];
            c4_q        <= lo_res[4];
            sum_hi0_q   <= hi0_res[3:0];
            carry_hi0_q <= hi0_res[4];
            sum_hi1_q   <= hi1_res[3:0];
            carry_hi1_q <= hi1_res[4];
            sum_q       <= {sel_sum_hi, sum_lo_q};
            cout_q      <= sel_carry;
        end
    end

    assign bus.output_sum  = sum_q;
    assign bus.output_Cout = cout_q;

endmodule

// File: tb/tb_eight_bit_select_adder.sv
// Directed and sweep bench for eight_bit_select_adder.
// The expected result after each edge is the 9-bit sum of the vector applied two edges earlier.
module tb_eight_bit_select_adder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference results of the last two vectors applied.
    logic [8:0] d1;
    logic [8:0] d2;

    eight_bit_select_adder_if bus ();

    eight_bit_select_adder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one vector across one edge. It returns the result expected after that edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [8:0] expected);
        bus.A   = a;
        bus.B   = b;
        bus.Cin = cin;
        @(posedge clk);
        #1;
        if (reset) begin
            expected = 9'h000;
            d1       = 9'h000;
            d2       = 9'h000;
        end else begin
            expected = d2;
            d2       = d1;
            d1       = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        end
    endtask

    task automatic test_reset();
        logic [8:0] e;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(8'hFF, 8'hFF, 1'b1, e);
            checks++;
            if ({bus.output_Cout, bus.output_sum} !== 9'h000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h want 000", i,
                         {bus.output_Cout, bus.output_sum});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(8'hFF, 8'hFF, 1'b1, e);
            checks++;
            if ({bus.output_Cout, bus.output_sum} !== 9'h000) begin
                errors++;
                $display("FAIL reset_release[%0d]: got %h want 000", i,
                         {bus.output_Cout, bus.output_sum});
            end
        end
        step(8'hFF, 8'hFF, 1'b1, e);
        checks++;
        if ({bus.output_Cout, bus.output_sum} !== 9'h1FF) begin
            errors++;
            $display("FAIL reset_first_result: got %h want 1ff",
                     {bus.output_Cout, bus.output_sum});
        end
    endtask

    task automatic test_latency();
        logic [8:0] e;
        step(8'h12, 8'h34, 1'b0, e);
        step(8'h01, 8'h01, 1'b1, e);
        checks++;
        if ({bus.output_Cout, bus.output_sum} === 9'h046) begin
            errors++;
            $display("FAIL latency_early: got %h one edge too soon",
                     {bus.output_Cout, bus.output_sum});
        end
        step(8'hAA, 8'h55, 1'b0, e);
        checks++;
        if ({bus.output_Cout, bus.output_sum} !== 9'h046) begin
            errors++;
            $display("FAIL latency: got %h want 046", {bus.output_Cout, bus.output_sum});
        end
        step(8'h00, 8'h00, 1'b0, e);
        checks++;
        if ({bus.output_Cout, bus.output_sum} !== 9'h003) begin
            errors++;
            $display("FAIL latency_next: got %h want 003", {bus.output_Cout, bus.output_sum});
        end
    endtask

    task automatic test_carry_select();
        logic [8:0] e;
        logic [7:0] av [3] = '{8'h0F, 8'hF0, 8'hFF};
        logic [7:0] bv [3] = '{8'h01, 8'h0F, 8'h00};
        logic       cv [3] = '{1'b0, 1'b1, 1'b1};
        logic [8:0] want [3] = '{9'h010, 9'h100, 9'h100};
        step(av[0], bv[0], cv[0], e);
        step(av[1], bv[1], cv[1], e);
        for (int i = 0; i < 3; i++) begin
            if (i < 1) step(av[2], bv[2], cv[2], e);
            else step(8'h00, 8'h00, 1'b0, e);
            checks++;
            if ({bus.output_Cout, bus.output_sum} !== want[i]) begin
                errors++;
                $display("FAIL carry_select[%0d]: got %h want %h", i,
                         {bus.output_Cout, bus.output_sum}, want[i]);
            end
        end
    endtask

    task automatic test_cin_toggle();
        logic [8:0] e;
        logic       cin;
        cin = 1'b0;
        step(8'h7F, 8'h80, cin, e);
        cin = 1'b1;
        step(8'h7F, 8'h80, cin, e);
        for (int i = 0; i < 8; i++) begin
            cin = ~cin;
            step(8'h7F, 8'h80, cin, e);
            checks++;
            // The result two edges back used the same Cin as this vector.
            if ({bus.output_Cout, bus.output_sum} !== (cin ? 9'h100 : 9'h0FF)) begin
                errors++;
                $display("FAIL cin_toggle[%0d]: got %h want %h", i,
                         {bus.output_Cout, bus.output_sum}, (cin ? 9'h100 : 9'h0FF));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        step(8'h11, 8'h22, 1'b0, e);
        step(8'h33, 8'h44, 1'b1, e);
        reset = 1'b1;
        step(8'h55, 8'h66, 1'b0, e);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(8'h80 + 8'(i), 8'h80, 1'b1, e);
            checks++;
            if ({bus.output_Cout, bus.output_sum} !== 9'h000) begin
                errors++;
                $display("FAIL reset_mid_zero[%0d]: got %h want 000", i,
                         {bus.output_Cout, bus.output_sum});
            end
            if (i == 1) break;
        end
        step(8'h00, 8'h00, 1'b0, e);
        checks++;
        if ({bus.output_Cout, bus.output_sum} !== 9'h101) begin
            errors++;
            $display("FAIL reset_mid_first: got %h want 101", {bus.output_Cout, bus.output_sum});
        end
        step(8'h00, 8'h00, 1'b0, e);
        checks++;
        if ({bus.output_Cout, bus.output_sum} !== 9'h102) begin
            errors++;
            $display("FAIL reset_mid_second: got %h want 102", {bus.output_Cout, bus.output_sum});
        end
    endtask

    task automatic test_sweep();
        logic [8:0] e;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 256; a++) begin
                for (int b = (a % 8); b < 256; b += 8) begin
                    step(8'(a), 8'(b), 1'(c), e);
                    checks++;
                    if ({bus.output_Cout, bus.output_sum} !== e) begin
                        errors++;
                        $display("FAIL sweep c=%0d a=%0d b=%0d: got %h want %h", c, a, b,
                                 {bus.output_Cout, bus.output_sum}, e);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        for (int i = 0; i < 1024; i++) begin
            step(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)), e);
            checks++;
            if ({bus.output_Cout, bus.output_sum} !== e) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i,
                         {bus.output_Cout, bus.output_sum}, e);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        d1      = 9'h000;
        d2      = 9'h000;
        reset   = 1'b1;
        bus.A   = 8'h00;
        bus.B   = 8'h00;
        bus.Cin = 1'b0;
        test_reset();
        test_latency();
        test_carry_select();
        test_cin_toggle();
        test_reset_mid();
        test_sweep();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
